// File: rtl/pentagon_pkg.sv
// pentagon_pkg: shared Pentagon-128 timing constants and counter widths
package pentagon_pkg;
    localparam int HC_W     = 10;
    localparam int VC_W     = 9;
    localparam int H_TOTAL  = 896;
    localparam int V_TOTAL  = 320;
    localparam int HS_START = 640;
    localparam int HS_END   = 704;
    localparam int VS_START = 240;
    localparam int VS_END   = 256;
endpackage

// File: rtl/pentagon_gen_if.sv
// pentagon_gen_if: clock-phase, column-count and composite-sync outputs of the timing generator
interface pentagon_gen_if;
    logic c1;
    logic c25;
    logic c2;
    logic c31;
    logic c3;
    logic b1;
    logic b2;
    logic b3;
    logic b4;
    logic b5;
    logic b6;
    logic ssi;
    modport master (output c1, c25, c2, c31, c3, b1, b2, b3, b4, b5, b6, ssi);
    modport slave  (input  c1, c25, c2, c31, c3, b1, b2, b3, b4, b5, b6, ssi);
endinterface

// File: rtl/pent_modn_counter.sv
// pent_modn_counter: modulo-N counter with enable, sync active-low reset, wrap flag and next-state view
module pent_modn_counter #(
    parameter int W = 10,
    parameter int N = 896
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         wrap
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        wrap  = en && (cnt_q == W'(N - 1));
        cnt_d = wrap ? '0 : cnt_q + W'(en);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
    assign nxt = cnt_d;
endmodule

// File: rtl/pentagon_gen.sv
// pentagon_gen: Pentagon-128 pixel/CPU clock divider, column count and composite sync generator
module pentagon_gen
    import pentagon_pkg::*;
#(
    parameter int H_TOT  = H_TOTAL,
    parameter int V_TOT  = V_TOTAL,
    parameter int HS_ON  = HS_START,
    parameter int HS_OFF = HS_END,
    parameter int VS_ON  = VS_START,
    parameter int VS_OFF = VS_END
) (
    input  logic           clk14m,
    input  logic           rst_n,
    pentagon_gen_if.master vid
);
    logic [HC_W-1:0] hc, hc_d;
    logic [VC_W-1:0] vc, vc_d;
    logic            hc_wrap;
    logic            c25_q, c25_d, ssi_q, ssi_d;

    pent_modn_counter #(.W(HC_W), .N(H_TOT)) u_hc (
        .clk(clk14m), .rst_n(rst_n), .en(1'b1), .cnt(hc), .nxt(hc_d), .wrap(hc_wrap)
    );

    pent_modn_counter #(.W(VC_W), .N(V_TOT)) u_vc (
        .clk(clk14m), .rst_n(rst_n), .en(hc_wrap), .cnt(vc), .nxt(vc_d), .wrap()
    );

    // decode from next-state counts so the registered outputs line up with hc/vc
    always_comb begin
        c25_d = hc_d[1] ^ hc_d[0];
        ssi_d = !((hc_d >= HC_W'(HS_ON) && hc_d < HC_W'(HS_OFF)) ||
                  (vc_d >= VC_W'(VS_ON) && vc_d < VC_W'(VS_OFF)));
    end

    always_ff @(posedge clk14m) begin
        if (!rst_n) begin
            c25_q <= 1'b0;
            ssi_q <= 1'b1;
        end else begin
            c25_q <= c25_d;
            ssi_q <= ssi_d;
        end
    end

    assign vid.c1  = hc[0];
    assign vid.c25 = c25_q;
    assign vid.c2  = hc[1];
    assign vid.c3  = hc[2];
    assign vid.c31 = hc[3];
    assign vid.b1  = hc[4];
    assign vid.b2  = hc[5];
    assign vid.b3  = hc[6];
    assign vid.b4  = hc[7];
    assign vid.b5  = hc[8];
    assign vid.b6  = hc[9];
    assign vid.ssi = ssi_q;
endmodule

// File: tb/tb_pentagon_gen.sv
// tb_pentagon_gen: scoreboard bench comparing every cycle against a time-since-reset timing model
module tb_pentagon_gen;
    import pentagon_pkg::*;

    // shortened frame keeps the run small while preserving a 16-line vsync and real line timing
    localparam int VT    = 22;
    localparam int VSS   = 4;
    localparam int VSE   = 20;
    localparam int FRAME = H_TOTAL * VT;

    logic clk14m = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk14m = ~clk14m;

    pentagon_gen_if vid();

    pentagon_gen #(.V_TOT(VT), .VS_ON(VSS), .VS_OFF(VSE)) dut (
        .clk14m(clk14m),
        .rst_n (rst_n),
        .vid   (vid)
    );

    logic [11:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int t          = 0;

    // expected {c1,c25,c2,c31,c3,b6..b1,ssi} t cycles after the last reset edge
    function automatic logic [11:0] model(input int tt);
        int hc, vc, col;
        logic ssi;
        hc  = tt % H_TOTAL;
        vc  = (tt / H_TOTAL) % VT;
        col = hc / 16;
        ssi = !((hc >= HS_START && hc < HS_END) || (vc >= VSS && vc < VSE));
        return {(hc % 2) == 1, (((hc + 1) / 2) % 2) == 1, ((hc / 2) % 2) == 1,
                ((hc / 8) % 2) == 1, ((hc / 4) % 2) == 1, 6'(col), ssi};
    endfunction

    task automatic step(input logic r);
        @(negedge clk14m) rst_n = r;
        @(posedge clk14m) t = r ? t + 1 : 0;
        exp_q.push_back(model(t));
    endtask

    initial begin
        logic [11:0] act, e;
        forever begin
            @(posedge clk14m);
            #1;
            if (exp_q.size() != 0) begin
                act = {vid.c1, vid.c25, vid.c2, vid.c31, vid.c3,
                       vid.b6, vid.b5, vid.b4, vid.b3, vid.b2, vid.b1, vid.ssi};
                e = exp_q.pop_front();
                compared++;
                if (act !== e) begin
                    mismatched++;
                    $display("FAIL outputs @%0t t=%0d hc=%0d vc=%0d got c1/c25/c2/c31/c3/b6..b1/ssi=%b expected %b",
                             $time, t, t % H_TOTAL, (t / H_TOTAL) % VT, act, e);
                end
            end
        end
    end

    initial begin
        int k;
        repeat (5) step(1'b0);
        repeat (2 * FRAME + H_TOTAL + 10) step(1'b1);
        k = $urandom_range(H_TOTAL - 1);
        while (!(((t / H_TOTAL) % VT) == VSS + 5 && (t % H_TOTAL) == k)) step(1'b1);
        repeat ($urandom_range(3, 1)) step(1'b0);
        repeat (H_TOTAL + 5) step(1'b1);
        repeat (3000) step($urandom_range(499) != 0);
        @(negedge clk14m);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
